// File: rtl/ps2_pkg.sv
// PS/2 receiver shared types: FSM state encoding, special scancodes
// and an odd-parity helper used by the frame checker.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_e;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  // True when byte plus parity bit hold an odd number of ones.
  function automatic logic odd_ok(
    input logic [7:0] b,
    input logic       p
  );
    return ^{b, p};
  endfunction

endpackage

// File: rtl/ps2_scancode_rx_if.sv
// Scancode output bundle from the PS/2 receiver to the decoder.
// master: receiver drives scancode/flag/frame_err; slave: consumer.
interface ps2_scancode_rx_if;

  logic [7:0] scancode;
  logic       flag;
  logic       frame_err;

  modport master (
    output scancode,
    output flag,
    output frame_err
  );

  modport slave (
    input scancode,
    input flag,
    input frame_err
  );

endinterface

// File: rtl/ps2_line_filter.sv
// Synchroniser + glitch filter + falling-edge pulse for one PS/2 line.
// Ports: vga_clk, reset (sync, high), line_in (async), level, fall.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic vga_clk,
  input  logic reset,
  input  logic line_in,
  output logic level,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // level only moves after FILTER_LEN consecutive samples that
  // disagree with it; any agreeing sample restarts the run.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      sync  <= 2'b11;
      cnt   <= '0;
      level <= 1'b1;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[0], line_in};
      fall <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        level <= sync[1];
        cnt   <= '0;
        fall  <= level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: 11-bit frames -> scancode + flag strobe.
// Ports: vga_clk, reset (sync, high), ps2_clk, ps2_data, rx (master:
// scancode, flag, frame_err). Optional macro PS2_BREAK_FILTER_EN
// swallows F0-prefixed break sequences instead of publishing them.
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic vga_clk,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  ps2_scancode_rx_if.master rx
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic       clk_lvl;
  logic       fall;
  logic [1:0] dsync;
  logic       din;

  ps2_state_e    state, state_d;
  logic [2:0]    bitcnt, bitcnt_d;
  logic [7:0]    shreg, shreg_d;
  logic          par, par_d;
  logic [TW-1:0] tcnt, tcnt_d;
  logic [7:0]    sc_q, sc_d;
  logic          flag_q, flag_d;
  logic          err_q, err_d;
`ifdef PS2_BREAK_FILTER_EN
  logic          bp, bp_d;
`endif

  ps2_line_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_clk_filt (
    .vga_clk(vga_clk),
    .reset  (reset),
    .line_in(ps2_clk),
    .level  (clk_lvl),
    .fall   (fall)
  );

  always_ff @(posedge vga_clk) begin
    if (reset) dsync <= 2'b11;
    else       dsync <= {dsync[0], ps2_data};
  end

  assign din = dsync[1];

  always_comb begin
    state_d  = state;
    bitcnt_d = bitcnt;
    shreg_d  = shreg;
    par_d    = par;
    sc_d     = sc_q;
    flag_d   = 1'b0;
    err_d    = 1'b0;
`ifdef PS2_BREAK_FILTER_EN
    bp_d     = bp;
`endif
    if (state == IDLE || fall) tcnt_d = '0;
    else                       tcnt_d = tcnt + 1'b1;

    if (fall) begin
      unique case (state)
        IDLE: begin
          if (!din) begin
            state_d  = DATA;
            bitcnt_d = 3'd0;
          end
        end
        DATA: begin
          shreg_d  = {din, shreg[7:1]};
          bitcnt_d = bitcnt + 3'd1;
          if (bitcnt == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = din;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (din && odd_ok(shreg, par)) begin
`ifdef PS2_BREAK_FILTER_EN
            // Byte after F0 is the released key: drop it.
            // E0 prefixes may sit between F0 and that key.
            if (bp && shreg != PS2_EXT) begin
              bp_d = 1'b0;
            end else if (shreg == PS2_BREAK) begin
              bp_d = 1'b1;
            end else begin
              sc_d   = shreg;
              flag_d = 1'b1;
            end
`else
            sc_d   = shreg;
            flag_d = 1'b1;
`endif
          end else begin
            err_d = 1'b1;
`ifdef PS2_BREAK_FILTER_EN
            bp_d  = 1'b0;
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state != IDLE &&
                 tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d = IDLE;
`ifdef PS2_BREAK_FILTER_EN
      bp_d    = 1'b0;
`endif
    end
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state  <= IDLE;
      bitcnt <= '0;
      shreg  <= '0;
      par    <= 1'b0;
      tcnt   <= '0;
      sc_q   <= 8'h00;
      flag_q <= 1'b0;
      err_q  <= 1'b0;
`ifdef PS2_BREAK_FILTER_EN
      bp     <= 1'b0;
`endif
    end else begin
      state  <= state_d;
      bitcnt <= bitcnt_d;
      shreg  <= shreg_d;
      par    <= par_d;
      tcnt   <= tcnt_d;
      sc_q   <= sc_d;
      flag_q <= flag_d;
      err_q  <= err_d;
`ifdef PS2_BREAK_FILTER_EN
      bp     <= bp_d;
`endif
    end
  end

  assign rx.scancode  = sc_q;
  assign rx.flag      = flag_q;
  assign rx.frame_err = err_q;

  // clk_lvl is only consumed through fall.
  logic unused_lvl;
  assign unused_lvl = clk_lvl;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Randomised + directed bench for ps2_scancode_rx against a
// frame-level reference model.
module tb_ps2_scancode_rx;

  import ps2_pkg::*;

  localparam int H  = 40;
  localparam int TO = 1000;

  logic vga_clk  = 1'b0;
  logic reset    = 1'b1;
  logic ps2_clk  = 1'b1;
  logic ps2_data = 1'b1;

  ps2_scancode_rx_if rx ();

  ps2_scancode_rx #(
    .FILTER_LEN    (8),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .vga_clk (vga_clk),
    .reset   (reset),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .rx      (rx)
  );

  always #5 vga_clk = ~vga_clk;

  int n_chk  = 0;
  int n_pass = 0;
  int nflag  = 0;
  int nerr   = 0;
  int nboth  = 0;
  int ndbl   = 0;
  logic prev_f = 1'b0;

  always @(negedge vga_clk) begin
    if (rx.flag) nflag = nflag + 1;
    if (rx.frame_err) nerr = nerr + 1;
    if (rx.flag && rx.frame_err) nboth = nboth + 1;
    if (rx.flag && prev_f) ndbl = ndbl + 1;
    prev_f = rx.flag;
  end

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk = n_chk + 1;
    if (got === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  // Reference state: last published byte, pending break.
  logic [7:0] m_sc;
  bit         m_pend;

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge vga_clk);
  endtask

  task automatic send_frame(
    input logic [7:0] b,
    input bit         flip,
    input bit         bstop,
    input int         nbits,
    input int         gl
  );
    logic [10:0] bits;
    logic        p;
    p = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
    if (flip) p = ~p;
    bits = {~bstop, p, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      wait_cyc(H / 2);
      ps2_data = bits[i];
      if (i == gl) begin
        wait_cyc(4);
        ps2_clk = 1'b0;
        wait_cyc(3);
        ps2_clk = 1'b1;
        wait_cyc(H / 2 - 7);
      end else begin
        wait_cyc(H / 2);
      end
      ps2_clk = 1'b0;
      wait_cyc(H);
      ps2_clk = 1'b1;
    end
    wait_cyc(H / 2);
    ps2_data = 1'b1;
  endtask

  task automatic do_frame(
    input logic [7:0] b,
    input bit         flip,
    input bit         bstop,
    input int         gl
  );
    int f0, e0, d0;
    int ef, ee;
    logic p;
    bit ok;
    f0 = nflag;
    e0 = nerr;
    d0 = ndbl;
    ef = 0;
    ee = 0;
    send_frame(b, flip, bstop, 11, gl);
    wait_cyc(100);
    p  = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
    if (flip) p = ~p;
    ok = !bstop && ($countones({b, p}) % 2 == 1);
    if (!ok) begin
      ee = 1;
      m_pend = 0;
    end else begin
`ifdef PS2_BREAK_FILTER_EN
      if (m_pend && b != PS2_EXT) begin
        m_pend = 0;
      end else if (b == PS2_BREAK) begin
        m_pend = 1;
      end else begin
        ef = 1;
        m_sc = b;
      end
`else
      ef = 1;
      m_sc = b;
`endif
    end
    check($sformatf("flags[%h]", b), nflag - f0, ef);
    check($sformatf("errs[%h]", b), nerr - e0, ee);
    check($sformatf("scancode[%h]", b),
          {24'd0, rx.scancode}, {24'd0, m_sc});
    check($sformatf("dblflag[%h]", b), ndbl - d0, 0);
  endtask

  initial begin
    int f0, e0;
    logic [7:0] rb;
    m_sc   = 8'h00;
    m_pend = 0;
    wait_cyc(5);
    check("rst_sc", {24'd0, rx.scancode}, 0);
    check("rst_flag", {31'd0, rx.flag}, 0);
    check("rst_err", {31'd0, rx.frame_err}, 0);
    reset = 1'b0;
    wait_cyc(20);

    do_frame(8'h2B, 0, 0, -1);
    do_frame(8'h15, 1, 0, -1);
    do_frame(8'hF0, 0, 0, -1);
    do_frame(8'h2B, 0, 0, -1);

    f0 = nflag;
    e0 = nerr;
    ps2_clk = 1'b0;
    wait_cyc(3);
    ps2_clk = 1'b1;
    wait_cyc(50);
    check("idle_glitch_flag", nflag - f0, 0);
    check("idle_glitch_err", nerr - e0, 0);
    do_frame(8'h33, 0, 0, 3);

    f0 = nflag;
    e0 = nerr;
    send_frame(8'h5A, 0, 0, 6, -1);
    wait_cyc(TO + 200);
    check("tmo_flag", nflag - f0, 0);
    check("tmo_err", nerr - e0, 0);
    m_pend = 0;
    do_frame(8'h22, 0, 0, -1);

    send_frame(8'h77, 0, 0, 5, -1);
    reset = 1'b1;
    wait_cyc(3);
    check("mid_rst_sc", {24'd0, rx.scancode}, 0);
    check("mid_rst_flag", {31'd0, rx.flag}, 0);
    check("mid_rst_err", {31'd0, rx.frame_err}, 0);
    reset = 1'b0;
    m_sc   = 8'h00;
    m_pend = 0;
    wait_cyc(20);
    do_frame(8'h34, 0, 0, -1);

    for (int i = 0; i < 24; i++) begin
      rb = 8'($urandom);
      if ($urandom_range(0, 5) == 0) rb = PS2_BREAK;
      else if ($urandom_range(0, 7) == 0) rb = PS2_EXT;
      do_frame(rb,
               $urandom_range(0, 4) == 0,
               $urandom_range(0, 7) == 0,
               -1);
    end

    check("never_both", nboth, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
